// File: rtl/svreal_addsub_arbiter.sv
// Round-robin arbiter that shares one two-stage svreal add/sub datapath among N_REQ requesters.
// Operands are aligned to OUT_EXP, combined with one guard bit, then saturated to OUT_WIDTH.
module svreal_addsub_arbiter #(
   parameter int N_REQ     = 4,
   parameter int A_WIDTH   = 16,
   parameter int A_EXP     = -8,
   parameter int B_WIDTH   = 17,
   parameter int B_EXP     = -9,
   parameter int OUT_WIDTH = 18,
   parameter int OUT_EXP   = -10,
   localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*A_WIDTH-1:0]   req_a,
   input  logic [N_REQ*B_WIDTH-1:0]   req_b,
   input  logic [N_REQ-1:0]           req_op,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [ID_W-1:0]            rsp_id,
   output logic [OUT_WIDTH-1:0]       rsp_result,
   output logic                       rsp_overflow
);

   localparam int A_SH   = A_EXP - OUT_EXP;
   localparam int A_LS   = (A_SH > 0) ? A_SH : 0;
   localparam int A_RS   = (A_SH > 0) ? 0 : -A_SH;
   localparam int B_SH   = B_EXP - OUT_EXP;
   localparam int B_LS   = (B_SH > 0) ? B_SH : 0;
   localparam int B_RS   = (B_SH > 0) ? 0 : -B_SH;
   localparam int A_AW   = A_WIDTH + A_LS;
   localparam int B_AW   = B_WIDTH + B_LS;
   localparam int MAX_AW = (A_AW > B_AW) ? A_AW : B_AW;
   // Wide enough for either aligned operand or the output, plus one guard bit.
   localparam int IW     = ((MAX_AW > OUT_WIDTH) ? MAX_AW : OUT_WIDTH) + 1;

   logic [ID_W-1:0]    last_grant;
   logic               s1_valid;
   logic [A_WIDTH-1:0] s1_a;
   logic [B_WIDTH-1:0] s1_b;
   logic               s1_op;
   logic [ID_W-1:0]    s1_id;

   logic               s2_can_load;
   logic               s1_can_load;
   logic               found;
   logic               fire;
   logic [ID_W-1:0]    win;

   assign s2_can_load = !rsp_valid || rsp_ready;
   assign s1_can_load = !s1_valid || s2_can_load;
   assign fire        = found && s1_can_load;

   // First valid requester strictly after last_grant, wrapping around.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         logic [ID_W-1:0] cand;
         cand = ID_W'((int'(last_grant) + k) % N_REQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (fire) req_ready[win] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= ID_W'(N_REQ - 1);
         s1_valid   <= 1'b0;
         s1_a       <= '0;
         s1_b       <= '0;
         s1_op      <= 1'b0;
         s1_id      <= '0;
      end else begin
         if (s1_can_load) s1_valid <= fire;
         if (fire) begin
            last_grant <= win;
            s1_a       <= req_a[win*A_WIDTH +: A_WIDTH];
            s1_b       <= req_b[win*B_WIDTH +: B_WIDTH];
            s1_op      <= req_op[win];
            s1_id      <= win;
         end
      end
   end

   logic signed [IW-1:0] a_ext, b_ext, a_al, b_al, sum;
   logic signed [IW-1:0] sat_max, sat_min;
   logic [OUT_WIDTH-1:0] res;
   logic                 ovf;

   assign sat_max = {{(IW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   assign sat_min = {{(IW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   // Left shift is lossless thanks to IW; right shift floors (arithmetic).
   always_comb begin
      a_ext = {{(IW-A_WIDTH){s1_a[A_WIDTH-1]}}, s1_a};
      b_ext = {{(IW-B_WIDTH){s1_b[B_WIDTH-1]}}, s1_b};
      a_al  = (a_ext <<< A_LS) >>> A_RS;
      b_al  = (b_ext <<< B_LS) >>> B_RS;
      sum   = s1_op ? (a_al - b_al) : (a_al + b_al);
      res   = sum[OUT_WIDTH-1:0];
      ovf   = 1'b0;
      if (sum > sat_max) begin
         res = sat_max[OUT_WIDTH-1:0];
         ovf = 1'b1;
      end else if (sum < sat_min) begin
         res = sat_min[OUT_WIDTH-1:0];
         ovf = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid    <= 1'b0;
         rsp_id       <= '0;
         rsp_result   <= '0;
         rsp_overflow <= 1'b0;
      end else if (s2_can_load) begin
         rsp_valid <= s1_valid;
         if (s1_valid) begin
            rsp_id       <= s1_id;
            rsp_result   <= res;
            rsp_overflow <= ovf;
         end
      end
   end

endmodule
